// File: rtl/riscv_defs.sv
// Shared constants and types for the instruction-fetch path.
// Word addresses drop the two byte-offset bits, giving a 30-bit address space.
package riscv_defs;

    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam int          WADDR_W        = 30;
    localparam int          INST_W         = 32;
    localparam int          ENTRY_W        = WADDR_W + INST_W;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        waddr_t              addr;
        logic [INST_W-1:0]   inst;
    } pf_entry_t;

    typedef enum logic {
        PF_RUN   = 1'b0,
        PF_FLUSH = 1'b1
    } pf_state_e;

    function automatic logic [31:0] byte_of(input waddr_t waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head view, same-cycle push+pop
// and a synchronous clear that discards both the contents and that cycle's push/pop.
module sync_fifo
    import riscv_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~i_clr;
    assign w_pop  = i_pop & ~i_clr & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries below r_count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(w_push && r_count == CNT_W'(DEPTH))
    );

endmodule

// File: rtl/inst_prefetch_buf.sv
// Sequential instruction prefetcher: keeps up to DEPTH words (stored + in flight)
// ahead of the core's PC, serves hits from the FIFO head and refetches on a jump.
module inst_prefetch_buf
    import riscv_defs::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] NOP_INST   = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr_i,
    input  logic        hold_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        dbg_state_o
);

    localparam int             CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    // Memory handshake: a request transfers on a cycle with mem_req_o & mem_gnt_i;
    // mem_req_o/mem_addr_o hold until then. Each request returns exactly one
    // mem_rvalid_i pulse, in issue order, on a later cycle.

    pf_state_e        r_state;
    pf_state_e        w_state_nxt;
    waddr_t           r_fetch_waddr;
    waddr_t           r_resp_waddr;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    waddr_t           w_fetch_nxt;
    waddr_t           w_resp_nxt;
    logic [CNT_W-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_discard_nxt;

    waddr_t           w_pc_waddr;
    logic [CNT_W-1:0] w_count;
    pf_entry_t        w_head;
    pf_entry_t        w_push_entry;
    logic             w_hit;
    logic             w_flush;
    logic             w_pop;
    logic             w_push;
    logic             w_req;
    logic             w_issue;
    logic             w_credit_ok;
    logic             w_unused;

    assign w_pc_waddr = pc_addr_i[31:2];
    assign w_unused   = &{1'b0, pc_addr_i[1:0]};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_flush),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign w_hit = (w_count != '0) && (w_head.addr == w_pc_waddr);

    // An empty FIFO only counts as a miss when the PC is not the next word
    // already on its way; otherwise the core simply waits for it.
    assign w_flush = (w_count != '0) ? !w_hit : (w_pc_waddr != r_resp_waddr);

    assign w_pop        = w_hit & ~hold_i;
    assign w_push       = mem_rvalid_i & (r_discard == '0) & ~w_flush;
    assign w_push_entry = '{addr: r_resp_waddr, inst: mem_rdata_i};
    assign w_credit_ok  = ({1'b0, w_count} + {1'b0, r_outstanding}) < CREDIT_MAX;
    assign w_issue      = w_req & mem_gnt_i;

    always_comb begin
        w_out_nxt     = r_outstanding + CNT_W'(w_issue) - CNT_W'(mem_rvalid_i);
        w_discard_nxt = r_discard;
        w_fetch_nxt   = r_fetch_waddr;
        w_resp_nxt    = r_resp_waddr;
        if (w_flush) begin
            // Everything still in flight after this edge (including a request
            // granted right now) belongs to the abandoned stream.
            w_discard_nxt = w_out_nxt;
            w_fetch_nxt   = w_pc_waddr;
            w_resp_nxt    = w_pc_waddr;
        end else begin
            if (mem_rvalid_i && r_discard != '0) w_discard_nxt = r_discard - 1'b1;
            if (w_issue) w_fetch_nxt = r_fetch_waddr + 1'b1;
            if (w_push)  w_resp_nxt  = r_resp_waddr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_waddr <= RESET_ADDR[31:2];
            r_resp_waddr  <= RESET_ADDR[31:2];
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_fetch_waddr <= w_fetch_nxt;
            r_resp_waddr  <= w_resp_nxt;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PF_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PF_RUN:   if (w_flush && w_discard_nxt != '0) w_state_nxt = PF_FLUSH;
            PF_FLUSH: if (w_discard_nxt == '0)            w_state_nxt = PF_RUN;
            default:  w_state_nxt = PF_RUN;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            PF_RUN:   w_req = w_credit_ok;
            PF_FLUSH: w_req = 1'b0;
            default:  w_req = 1'b0;
        endcase
    end

    // Request and stall are forced low while rst is held so the pins show
    // their idle values immediately, not just after the registers settle.
    assign mem_req_o    = w_req & ~rst;
    assign mem_addr_o   = byte_of(r_fetch_waddr);
    assign inst_valid_o = w_hit;
    assign inst_o       = w_hit ? w_head.inst : NOP_INST;
    assign stall_o      = ~w_hit & ~rst;
    assign dbg_state_o  = r_state;

    a_rvalid_has_request: assert property (
        @(posedge clk) disable iff (rst) !(mem_rvalid_i && r_outstanding == '0)
    );

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf: per-cycle vector table against a
// variable-latency memory model, plus a wrap-around instance and an async-reset sequence.
module tb_inst_prefetch_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr_i;
    logic        hold_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        dbg_state_o;

    logic [31:0] wrap_pc;
    logic        wrap_hold;
    logic        wrap_gnt;
    logic        wrap_rvalid;
    logic [31:0] wrap_rdata;
    logic [31:0] wrap_inst;
    logic        wrap_valid;
    logic        wrap_stall;
    logic        wrap_req;
    logic [31:0] wrap_addr;
    logic        wrap_dbg;

    always #5 clk = ~clk;

    inst_prefetch_buf u_dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr_i    (pc_addr_i),
        .hold_i       (hold_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    inst_prefetch_buf #(.RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .pc_addr_i    (wrap_pc),
        .hold_i       (wrap_hold),
        .inst_o       (wrap_inst),
        .inst_valid_o (wrap_valid),
        .stall_o      (wrap_stall),
        .mem_req_o    (wrap_req),
        .mem_addr_o   (wrap_addr),
        .mem_gnt_i    (wrap_gnt),
        .mem_rvalid_i (wrap_rvalid),
        .mem_rdata_i  (wrap_rdata),
        .dbg_state_o  (wrap_dbg)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hold;
        logic        gnt;
        logic        ev;
        logic [31:0] inst;
        logic        req;
        logic [31:0] addr;
        logic        fl;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t        vecs[36];
    int          nv;
    mreq_t       mem_q[$];
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;
    logic [31:0] wrap_addr_exp[5];
    logic        wrap_req_exp[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic hold, input logic gnt,
                       input logic ev, input logic [31:0] inst, input logic req,
                       input logic [31:0] addr, input logic fl);
        vecs[nv] = '{pc: pc, hold: hold, gnt: gnt, ev: ev, inst: inst,
                     req: req, addr: addr, fl: fl};
        nv++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},   32'(mem_req_o),    32'h0);
        chk({tag, " addr"},  mem_addr_o,        32'h0);
        chk({tag, " valid"}, 32'(inst_valid_o), 32'h0);
        chk({tag, " inst"},  inst_o,            NOP);
        chk({tag, " stall"}, 32'(stall_o),      32'h0);
        chk({tag, " state"}, 32'(dbg_state_o),  32'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Memory model: a grant seen at an edge is answered lat cycles later.
    task automatic advance();
        logic        acc;
        logic [31:0] acc_addr;
        logic        had_rv;
        mreq_t       m;
        acc      = mem_req_o && mem_gnt_i;
        acc_addr = mem_addr_o;
        had_rv   = mem_rvalid_i;
        @(posedge clk);
        #1;
        cyc++;
        if (had_rv && mem_q.size() > 0) mem_q.delete(0);
        if (acc) begin
            m.addr = acc_addr;
            m.due  = cyc + lat - 1;
            mem_q.push_back(m);
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_q[0].addr + 32'h100;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic apply_vec(input int i);
        pc_addr_i = vecs[i].pc;
        hold_i    = vecs[i].hold;
        mem_gnt_i = vecs[i].gnt;
        @(negedge clk);
        chk($sformatf("v%0d valid", i), 32'(inst_valid_o), 32'(vecs[i].ev));
        chk($sformatf("v%0d inst", i),  inst_o,            vecs[i].inst);
        chk($sformatf("v%0d stall", i), 32'(stall_o),      32'(!vecs[i].ev));
        chk($sformatf("v%0d req", i),   32'(mem_req_o),    32'(vecs[i].req));
        chk($sformatf("v%0d addr", i),  mem_addr_o,        vecs[i].addr);
        chk($sformatf("v%0d state", i), 32'(dbg_state_o),  32'(vecs[i].fl));
        if (i < 5) begin
            chk($sformatf("wrap%0d req", i),   32'(wrap_req),   32'(wrap_req_exp[i]));
            chk($sformatf("wrap%0d addr", i),  wrap_addr,       wrap_addr_exp[i]);
            chk($sformatf("wrap%0d valid", i), 32'(wrap_valid), 32'h0);
            chk($sformatf("wrap%0d inst", i),  wrap_inst,       NOP);
            chk($sformatf("wrap%0d stall", i), 32'(wrap_stall), 32'h1);
            chk($sformatf("wrap%0d state", i), 32'(wrap_dbg),   32'h0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        pc_addr_i    = '0;
        hold_i       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        wrap_pc      = 32'hFFFF_FFF8;
        wrap_hold    = 1'b0;
        wrap_gnt     = 1'b1;
        wrap_rvalid  = 1'b0;
        wrap_rdata   = '0;
        lat          = 1;
        cyc          = 0;
        n_checks     = 0;
        n_fail       = 0;
        nv           = 0;
        wrap_addr_exp[0] = 32'hFFFF_FFF8; wrap_req_exp[0] = 1'b1;
        wrap_addr_exp[1] = 32'hFFFF_FFFC; wrap_req_exp[1] = 1'b1;
        wrap_addr_exp[2] = 32'h0000_0000; wrap_req_exp[2] = 1'b1;
        wrap_addr_exp[3] = 32'h0000_0004; wrap_req_exp[3] = 1'b1;
        wrap_addr_exp[4] = 32'h0000_0008; wrap_req_exp[4] = 1'b0;

        //    pc        hold  gnt   ev    inst          req   addr          fl
        // streaming, 1-cycle memory, then 5 cycles without grant (0..14)
        add(32'h00, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h00, 1'b0);
        add(32'h00, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h04, 1'b0);
        add(32'h00, 1'b0, 1'b1, 1'b1, 32'h100,      1'b1, 32'h08, 1'b0);
        add(32'h04, 1'b0, 1'b1, 1'b1, 32'h104,      1'b1, 32'h0C, 1'b0);
        add(32'h08, 1'b0, 1'b1, 1'b1, 32'h108,      1'b1, 32'h10, 1'b0);
        add(32'h0C, 1'b0, 1'b0, 1'b1, 32'h10C,      1'b1, 32'h14, 1'b0);
        add(32'h10, 1'b0, 1'b0, 1'b1, 32'h110,      1'b1, 32'h14, 1'b0);
        add(32'h14, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 32'h14, 1'b0);
        add(32'h14, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 32'h14, 1'b0);
        add(32'h14, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 32'h14, 1'b0);
        add(32'h14, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h14, 1'b0);
        add(32'h14, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h18, 1'b0);
        add(32'h14, 1'b0, 1'b1, 1'b1, 32'h114,      1'b1, 32'h1C, 1'b0);
        add(32'h18, 1'b0, 1'b1, 1'b1, 32'h118,      1'b1, 32'h20, 1'b0);
        add(32'h1C, 1'b0, 1'b1, 1'b1, 32'h11C,      1'b1, 32'h24, 1'b0);
        // hold while the FIFO fills to DEPTH, then release (15..25)
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b1, 32'h28, 1'b0);
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b1, 32'h2C, 1'b0);
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b0, 32'h30, 1'b0);
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b0, 32'h30, 1'b0);
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b0, 32'h30, 1'b0);
        add(32'h20, 1'b1, 1'b1, 1'b1, 32'h120,      1'b0, 32'h30, 1'b0);
        add(32'h20, 1'b0, 1'b1, 1'b1, 32'h120,      1'b0, 32'h30, 1'b0);
        add(32'h24, 1'b0, 1'b1, 1'b1, 32'h124,      1'b1, 32'h30, 1'b0);
        add(32'h28, 1'b0, 1'b1, 1'b1, 32'h128,      1'b1, 32'h34, 1'b0);
        add(32'h2C, 1'b0, 1'b1, 1'b1, 32'h12C,      1'b1, 32'h38, 1'b0);
        add(32'h30, 1'b0, 1'b1, 1'b1, 32'h130,      1'b1, 32'h3C, 1'b0);
        // jump to 0x80 with a 2-cycle memory and two requests in flight (26..35)
        add(32'h00, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h00, 1'b0);
        add(32'h00, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h04, 1'b0);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h08, 1'b0);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b0, 32'h80, 1'b1);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b0, 32'h80, 1'b1);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h80, 1'b0);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h84, 1'b0);
        add(32'h80, 1'b0, 1'b1, 1'b0, NOP,          1'b1, 32'h88, 1'b0);
        add(32'h80, 1'b0, 1'b1, 1'b1, 32'h180,      1'b1, 32'h8C, 1'b0);
        add(32'h84, 1'b0, 1'b1, 1'b1, 32'h184,      1'b1, 32'h90, 1'b0);

        #2;
        chk_reset("por");
        chk("por wrap addr", wrap_addr, 32'hFFFF_FFF8);
        chk("por wrap req",  32'(wrap_req), 32'h0);

        lat = 1;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            apply_vec(i);
            advance();
        end

        lat = 2;
        do_reset();
        for (int i = 26; i < 36; i++) begin
            apply_vec(i);
            advance();
        end

        // Re-enter FLUSH, then assert rst between clock edges.
        lat = 2;
        do_reset();
        for (int i = 26; i < 29; i++) begin
            apply_vec(i);
            advance();
        end
        apply_vec(29);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async");

        lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_vec(i);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
